code_entry: RTL and testbench
=============================

# code_entry

Bit-serial code entry sequencer for the access-control datapath. Shifts user-entered bits into a `CODE_W`-bit register and presents it on `entered` to the `comparator` block. Samples the comparator's `match` result and drives the unlock, error and lockout indications. It is the producer/consumer counterpart of `comparator`: it drives `entered` and consumes `match`.

## Interface
Parameters:
- `CODE_W`, 4, code width; must equal the comparator's input width.
- `MAX_TRIES`, 3, consecutive failed attempts that trigger lockout (≥1).
- `UNLOCK_CYCLES`, 8, cycles `unlocked` stays high after a correct code (≥1).
- `LOCKOUT_CYCLES`, 16, cycles `locked` stays high after `MAX_TRIES` failures (≥1).

Ports:
- `clk`, in, 1, single clock; all state updates on rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `bit_valid`, in, 1, one-cycle strobe: `bit_in` is a new code bit.
- `bit_in`, in, 1, code bit, entered MSB first.
- `clear`, in, 1, discard the partial entry.
- `match`, in, 1, combinational result from `comparator` for the current `entered`.
- `entered`, out, `CODE_W`, registered code, wired to `comparator.entered`.
- `unlocked`, out, 1, high while access is granted.
- `error`, out, 1, one-cycle pulse on a failed attempt.
- `locked`, out, 1, high during lockout.
- `fail_cnt`, out, `$clog2(MAX_TRIES+1)`, consecutive failures so far.
- `busy`, out, 1, high in any state other than COLLECT.

## Operation
States: COLLECT, CHECK, UNLOCK, LOCKOUT. On reset the block enters COLLECT, and all outputs are 0.

- **COLLECT**
  - `clear` has priority over `bit_valid`: `entered`←0 and the bit counter←0.
  - Otherwise, on `bit_valid`: `entered`←{`entered[CODE_W-2:0]`, `bit_in`} and the counter increments.
  - When the `CODE_W`-th bit is accepted, the counter←0 and the next state is CHECK.
- **CHECK** (exactly 1 cycle): `entered` is stable and `match` is sampled.
  - `match`=1: `fail_cnt`←0, the timer is loaded with `UNLOCK_CYCLES`, next state UNLOCK.
  - `match`=0: `error` pulses on the next cycle and `fail_cnt` increments.
    - If the new count equals `MAX_TRIES`: the timer is loaded with `LOCKOUT_CYCLES`, next state LOCKOUT.
    - Otherwise: `entered`←0, next state COLLECT.
- **UNLOCK**: `unlocked`=1 and the timer decrements. When the timer reaches 1: `entered`←0, next state COLLECT.
- **LOCKOUT**: `locked`=1 and the timer decrements. When the timer reaches 1: `fail_cnt`←0, `entered`←0, next state COLLECT.
- `bit_valid` and `clear` are ignored outside COLLECT; bits presented there are dropped, not queued.
- The timer width is `$clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1)`. The bit counter width is `$clog2(CODE_W)`, minimum 1.

## Timing
- Bit accepted at edge N is visible on `entered` after edge N.
- Last bit accepted at edge N → CHECK during cycle N→N+1 → `unlocked` or `error` or `locked` asserted after edge N+1.
- `unlocked` is high for exactly `UNLOCK_CYCLES` cycles; `locked` is high for exactly `LOCKOUT_CYCLES` cycles.
- The earliest next bit is accepted on the edge after the block returns to COLLECT.
- `error` is a single-cycle pulse. On the `MAX_TRIES`-th failure, `error` and `locked` rise on the same edge.
- `rst` mid-operation, in any state, aborts everything: COLLECT, all outputs 0, partial entry and `fail_cnt` discarded.
- `clear` and the final `bit_valid` in the same cycle: clear wins, and no CHECK occurs.

## Configuration
- `CODE_ENTRY_LOCKOUT_EN` defined: lockout behaves as above.
- `CODE_ENTRY_LOCKOUT_EN` undefined:
  - LOCKOUT is never entered and `locked` is tied 0.
  - A failure always returns to COLLECT.
  - `fail_cnt` saturates at `MAX_TRIES` and clears only on a match or reset.

## Test plan
- **Correct code.** Defaults, comparator code 4'b1110. Strobe bits 1,1,1,0 on consecutive cycles → `entered`=4'b1110, CHECK, then `unlocked`=1 for 8 cycles, `fail_cnt`=0, then COLLECT with `entered`=0.
- **Single failure.** Enter 4'b1010 → one-cycle `error`, `fail_cnt`=1, back to COLLECT, `unlocked` stays 0.
- **Lockout.** Three wrong codes in a row → on the third, `error` and `locked` rise together. `locked` stays high for 16 cycles, during which `bit_valid` strobes are ignored (`entered` unchanged). Afterward `fail_cnt`=0.
- **Clear and priority.** Enter 1,1 then assert `clear` → `entered`=0. Assert `clear` together with the 4th `bit_valid` → no CHECK, `entered`=0, counter=0.
- **Reset mid-operation.** Assert `rst` during UNLOCK, and separately after two failures → all outputs 0 next cycle, `fail_cnt`=0, state COLLECT.
- **Lockout compiled out.** Build without `CODE_ENTRY_LOCKOUT_EN`, enter four wrong codes → four `error` pulses, `locked` never 1, `fail_cnt` saturates at 3. A subsequent 4'b1110 gives `unlocked` and `fail_cnt`=0.

Source files
------------

// File: rtl/code_entry.sv
// rtl/code_entry.sv - bit-serial code entry sequencer with unlock/error/lockout indications
//
// Shifts code bits in MSB first, presents the registered code on `entered`
// to the comparator, samples `match` for one cycle, then grants access for
// UNLOCK_CYCLES or, after MAX_TRIES consecutive failures, locks out for
// LOCKOUT_CYCLES.
//
// Build option: CODE_ENTRY_LOCKOUT_EN
//   defined   - MAX_TRIES consecutive failures enter the LOCKOUT state.
//   undefined - LOCKOUT is never entered, `locked` is tied 0, and `fail_cnt`
//               saturates at MAX_TRIES until a match or reset.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   bit_valid  in   strobe, bit_in carries a new code bit
//   bit_in     in   code bit, MSB first
//   clear      in   discard the partial entry (wins over bit_valid)
//   match      in   comparator result for the current `entered`
//   entered    out  registered code under entry / under check
//   unlocked   out  high while access is granted
//   error      out  one-cycle pulse per failed attempt
//   locked     out  high during lockout
//   fail_cnt   out  consecutive failed attempts
//   busy       out  high whenever not collecting bits
module code_entry #(
  parameter int CODE_W         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bit_valid,
  input  logic                             bit_in,
  input  logic                             clear,
  input  logic                             match,
  output logic [CODE_W-1:0]                entered,
  output logic                             unlocked,
  output logic                             error,
  output logic                             locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
  output logic                             busy
);

  localparam int FC_W    = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_UNLOCK  = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CODE_W - 1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] T_UNLOCK = TMR_W'(UNLOCK_CYCLES);
  localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);
`ifdef CODE_ENTRY_LOCKOUT_EN
  localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCKOUT_CYCLES);
`endif

  logic [1:0]        state_q,   state_d;
  logic [CODE_W-1:0] entered_q, entered_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [TMR_W-1:0]  timer_q,   timer_d;
  logic [FC_W-1:0]   fail_q,    fail_d;
  logic              error_q,   error_d;
  logic [FC_W-1:0]   fail_inc;

  always_comb begin
    state_d   = state_q;
    entered_d = entered_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    fail_d    = fail_q;
    error_d   = 1'b0;
    fail_inc  = fail_q + FC_W'(1);

    case (state_q)
      S_COLLECT: begin
        if (clear) begin
          entered_d = '0;
          cnt_d     = '0;
        end else if (bit_valid) begin
          // Shift left, new bit lands in the LSB; the cast also covers CODE_W == 1.
          entered_d = CODE_W'({entered_q, bit_in});
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_CHECK: begin
        if (match) begin
          fail_d  = '0;
          timer_d = T_UNLOCK;
          state_d = S_UNLOCK;
        end else begin
          error_d = 1'b1;
`ifdef CODE_ENTRY_LOCKOUT_EN
          fail_d = fail_inc;
          if (fail_inc == FC_MAX) begin
            // Keep the failed code visible through the lockout.
            timer_d = T_LOCK;
            state_d = S_LOCKOUT;
          end else begin
            entered_d = '0;
            state_d   = S_COLLECT;
          end
`else
          if (fail_q != FC_MAX) begin
            fail_d = fail_inc;
          end
          entered_d = '0;
          state_d   = S_COLLECT;
`endif
        end
      end

      S_UNLOCK: begin
        timer_d = timer_q - T_ONE;
        if (timer_q == T_ONE) begin
          entered_d = '0;
          state_d   = S_COLLECT;
        end
      end

      S_LOCKOUT: begin
        timer_d = timer_q - T_ONE;
        if (timer_q == T_ONE) begin
          fail_d    = '0;
          entered_d = '0;
          state_d   = S_COLLECT;
        end
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_COLLECT;
      entered_q <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      fail_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      error_q   <= error_d;
    end
  end

  assign entered  = entered_q;
  assign unlocked = (state_q == S_UNLOCK);
  assign error    = error_q;
`ifdef CODE_ENTRY_LOCKOUT_EN
  assign locked   = (state_q == S_LOCKOUT);
`else
  assign locked   = 1'b0;
`endif
  assign fail_cnt = fail_q;
  assign busy     = (state_q != S_COLLECT);

endmodule

// File: tb/tb_code_entry.sv
// tb/tb_code_entry.sv - self-checking bench for code_entry with an attempt-outcome scoreboard
module tb_code_entry;

  localparam logic [3:0] CODE_OK = 4'b1110;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid;
  logic       bit_in;
  logic       clear;
  logic       match;
  logic [3:0] entered;
  logic       unlocked;
  logic       error;
  logic       locked;
  logic [1:0] fail_cnt;
  logic       busy;

  always #5 clk = ~clk;

  // Comparator stand-in
  assign match = (entered == CODE_OK);

  code_entry dut (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
    .match     (match),
    .entered   (entered),
    .unlocked  (unlocked),
    .error     (error),
    .locked    (locked),
    .fail_cnt  (fail_cnt),
    .busy      (busy)
  );

  typedef struct {
    logic       is_unlock;
    logic [1:0] fc;
    logic       lk;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_fail   = 0;
  logic unl_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a full code and record the outcome the model predicts.
  task automatic send_code(input logic [3:0] code);
    exp_t e;
    if (code == CODE_OK) begin
      m_fail = 0;
      e = '{1'b1, 2'd0, 1'b0};
    end else begin
`ifdef CODE_ENTRY_LOCKOUT_EN
      m_fail++;
      e = '{1'b0, 2'(m_fail), (m_fail == 3)};
      if (m_fail == 3) m_fail = 0;
`else
      if (m_fail < 3) m_fail++;
      e = '{1'b0, 2'(m_fail), 1'b0};
`endif
    end
    sb.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = code[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    check_eq("idle_timeout", busy, 0);
  endtask

  task automatic strobe(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Outcome monitor: each error pulse or unlock rise consumes one prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (error || (unlocked && !unl_prev))) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_eq("sb_unlocked", unlocked, e.is_unlock);
        check_eq("sb_error", error, !e.is_unlock);
        check_eq("sb_fail_cnt", fail_cnt, e.fc);
        check_eq("sb_locked", locked, e.lk);
      end
    end
    unl_prev = unlocked;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
    tick();
    tick();
    check_eq("rst_entered", entered, 0);
    check_eq("rst_unlocked", unlocked, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_fail_cnt", fail_cnt, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Correct code
    send_code(CODE_OK);
    check_eq("ok_entered_at_check", entered, 4'hE);
    check_eq("ok_busy_in_check", busy, 1);
    tick();
    n = 0;
    while (unlocked && n < 40) begin
      n++;
      tick();
    end
    check_eq("unlock_len", n, 8);
    check_eq("ok_entered_after", entered, 0);
    check_eq("ok_busy_after", busy, 0);
    check_eq("ok_fail_cnt", fail_cnt, 0);

    // Single failure
    send_code(4'b1010);
    tick();
    check_eq("fail1_error", error, 1);
    check_eq("fail1_fail_cnt", fail_cnt, 1);
    check_eq("fail1_busy", busy, 0);
    check_eq("fail1_entered", entered, 0);
    check_eq("fail1_unlocked", unlocked, 0);
    tick();
    check_eq("fail1_error_pulse", error, 0);

`ifdef CODE_ENTRY_LOCKOUT_EN
    send_code(4'b0101);
    wait_idle();
    check_eq("fail2_fail_cnt", fail_cnt, 2);
    send_code(4'b0011);
    tick();
    check_eq("lock_error", error, 1);
    check_eq("lock_locked", locked, 1);
    n = 0;
    while (locked && n < 40) begin
      check_eq("lock_entered_frozen", entered, 4'h3);
      n++;
      bit_valid = 1'b1;
      bit_in    = n[0];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check_eq("lock_len", n, 16);
    check_eq("lock_fail_cnt_after", fail_cnt, 0);
    check_eq("lock_entered_after", entered, 0);
`else
    send_code(4'b0101);
    wait_idle();
    check_eq("fail2_fail_cnt", fail_cnt, 2);
    send_code(4'b0011);
    wait_idle();
    check_eq("fail3_fail_cnt", fail_cnt, 3);
    check_eq("fail3_locked", locked, 0);
    send_code(4'b0000);
    wait_idle();
    check_eq("fail4_fail_cnt_sat", fail_cnt, 3);
    check_eq("fail4_locked", locked, 0);
`endif
    send_code(CODE_OK);
    wait_idle();
    check_eq("recover_fail_cnt", fail_cnt, 0);

    // Clear and priority
    strobe(1'b1);
    strobe(1'b1);
    check_eq("clr_partial", entered, 4'b0011);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_entered", entered, 0);
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b1);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    clear = 1'b0; bit_valid = 1'b0;
    check_eq("clr_prio_entered", entered, 0);
    check_eq("clr_prio_busy", busy, 0);
    tick();
    check_eq("clr_prio_no_check", busy, 0);
    send_code(CODE_OK);
    check_eq("clr_cnt_reset_entered", entered, 4'hE);
    check_eq("clr_cnt_reset_busy", busy, 1);
    wait_idle();

    // Reset during UNLOCK
    send_code(CODE_OK);
    tick();
    tick();
    check_eq("rst_unl_pre", unlocked, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_fail = 0;
    check_eq("rst_unl_unlocked", unlocked, 0);
    check_eq("rst_unl_busy", busy, 0);
    check_eq("rst_unl_entered", entered, 0);
    check_eq("rst_unl_fail_cnt", fail_cnt, 0);

    // Reset after two failures
    send_code(4'b1010);
    wait_idle();
    send_code(4'b0101);
    wait_idle();
    check_eq("rst_ff_pre", fail_cnt, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_fail = 0;
    check_eq("rst_ff_fail_cnt", fail_cnt, 0);
    check_eq("rst_ff_error", error, 0);
    check_eq("rst_ff_busy", busy, 0);
    check_eq("rst_ff_locked", locked, 0);
    tick();

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
